param_adjust: RTL and testbench

//  Adjusts the two operating set-points (frequency code, current code) with the board
//  up/down pushbuttons, downstream of the frequency/current selector.
//  The selector's frec/cor enables pick which set-point the buttons act on.

---
 rtl/param_adjust_pkg.sv | 32 +++
 rtl/param_adjust_btn_cond.sv | 70 +++++++
 rtl/param_adjust.sv | 98 +++++++++
 tb/tb_param_adjust.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/param_adjust_pkg.sv
// Shared set-point constants and target-select helper for the parameter adjust path.
`timescale 1ns/1ps
package param_adjust_pkg;

    // Set-point format shared with the generator and display stages
    localparam int unsigned SP_W        = 4;
    localparam int unsigned SP_FREC_MAX = 9;
    localparam int unsigned SP_COR_MAX  = 9;
    localparam int unsigned SP_FREC_RST = 0;
    localparam int unsigned SP_COR_RST  = 0;

    // Button timing from the 100 MHz board clock: 5 ms debounce, 250 ms repeat
    localparam int unsigned SP_CLK_HZ      = 100_000_000;
    localparam int unsigned SP_DB_CYCLES   = SP_CLK_HZ / 200;
    localparam int unsigned SP_RPT_CYCLES  = SP_CLK_HZ / 4;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_FREC,
        TGT_COR
    } target_e;

    // Exactly one selector enable picks a target; none or both means no target
    function automatic target_e sel_target(input logic frec_en, input logic cor_en);
        case ({frec_en, cor_en})
            2'b10:   return TGT_FREC;
            2'b01:   return TGT_COR;
            default: return TGT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/param_adjust_btn_cond.sv
// Pushbutton conditioner: 2-FF sync, debounce, rising-edge step and auto-repeat.
`timescale 1ns/1ps
module btn_cond
    import param_adjust_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = SP_DB_CYCLES,
    parameter int unsigned RPT_CYCLES = SP_RPT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic step
);

    localparam int unsigned DBW = $clog2(DB_CYCLES);
    localparam int unsigned RPW = $clog2(RPT_CYCLES);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [RPW-1:0] RPT_LAST = RPW'(RPT_CYCLES - 1);

    logic           s1;
    logic           s2;
    logic           lvl;
    logic [DBW-1:0] db_cnt;
    logic [RPW-1:0] rpt_cnt;

    // Bring the raw button into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Debounce the synced level, emit a step on the press and every repeat period while held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl     <= 1'b0;
            db_cnt  <= '0;
            rpt_cnt <= '0;
            step    <= 1'b0;
        end else begin
            step <= 1'b0;

            if (s2 == lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                lvl    <= s2;
                step   <= s2;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end

            // The repeat counter starts on the cycle after the debounced rise,
            // so the first repeat lands RPT_CYCLES after the initial step
            if (!lvl) begin
                rpt_cnt <= '0;
            end else if (rpt_cnt == RPT_LAST) begin
                rpt_cnt <= '0;
                step    <= 1'b1;
            end else begin
                rpt_cnt <= rpt_cnt + RPW'(1);
            end
        end
    end

endmodule

// File: rtl/param_adjust.sv
// Frequency/current set-point adjust: button conditioning, target select, saturating step.
`timescale 1ns/1ps
module param_adjust
    import param_adjust_pkg::*;
#(
    parameter int unsigned W          = SP_W,
    parameter int unsigned FREC_MAX   = SP_FREC_MAX,
    parameter int unsigned COR_MAX    = SP_COR_MAX,
    parameter int unsigned FREC_RST   = SP_FREC_RST,
    parameter int unsigned COR_RST    = SP_COR_RST,
    parameter int unsigned DB_CYCLES  = SP_DB_CYCLES,
    parameter int unsigned RPT_CYCLES = SP_RPT_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frec_en,
    input  logic         cor_en,
    input  logic         btn_up,
    input  logic         btn_down,
    output logic [W-1:0] frec_val,
    output logic [W-1:0] cor_val,
    output logic         upd
);

    localparam logic [W-1:0] FMAX = W'(FREC_MAX);
    localparam logic [W-1:0] CMAX = W'(COR_MAX);
    localparam logic [W-1:0] FRST = W'(FREC_RST);
    localparam logic [W-1:0] CRST = W'(COR_RST);

    logic         step_up;
    logic         step_dn;
    logic [W-1:0] frec_nxt;
    logic [W-1:0] cor_nxt;
    logic         chg_nxt;
    logic         chg;
    target_e      tgt;

    btn_cond #(.DB_CYCLES(DB_CYCLES), .RPT_CYCLES(RPT_CYCLES)) u_up (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_up),
        .step  (step_up)
    );

    btn_cond #(.DB_CYCLES(DB_CYCLES), .RPT_CYCLES(RPT_CYCLES)) u_down (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_down),
        .step  (step_dn)
    );

    // Apply a single up or down step to the selected set-point, saturating at the limits
    always_comb begin
        frec_nxt = frec_val;
        cor_nxt  = cor_val;
        chg_nxt  = 1'b0;
        tgt      = sel_target(frec_en, cor_en);
        if (step_up ^ step_dn) begin
            case (tgt)
                TGT_FREC: begin
                    if (step_up && frec_val != FMAX) begin
                        frec_nxt = frec_val + W'(1);
                        chg_nxt  = 1'b1;
                    end else if (step_dn && frec_val != '0) begin
                        frec_nxt = frec_val - W'(1);
                        chg_nxt  = 1'b1;
                    end
                end
                TGT_COR: begin
                    if (step_up && cor_val != CMAX) begin
                        cor_nxt = cor_val + W'(1);
                        chg_nxt = 1'b1;
                    end else if (step_dn && cor_val != '0) begin
                        cor_nxt = cor_val - W'(1);
                        chg_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Set-point registers; upd trails the change by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frec_val <= FRST;
            cor_val  <= CRST;
            chg      <= 1'b0;
            upd      <= 1'b0;
        end else begin
            frec_val <= frec_nxt;
            cor_val  <= cor_nxt;
            chg      <= chg_nxt;
            upd      <= chg;
        end
    end

endmodule

// File: tb/tb_param_adjust.sv
// Directed bench for param_adjust with short debounce/repeat timing.
`timescale 1ns/1ps
module tb_param_adjust;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frec_en;
    logic       cor_en;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] frec_val;
    logic [3:0] cor_val;
    logic       upd;

    int unsigned n_cmp   = 0;
    int unsigned n_err   = 0;
    int unsigned upd_cnt = 0;
    int unsigned base;

    param_adjust #(
        .W          (4),
        .FREC_MAX   (9),
        .COR_MAX    (9),
        .FREC_RST   (0),
        .COR_RST    (0),
        .DB_CYCLES  (4),
        .RPT_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .frec_en  (frec_en),
        .cor_en   (cor_en),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .frec_val (frec_val),
        .cor_val  (cor_val),
        .upd      (upd)
    );

    always #5 clk = ~clk;

    // Running count of upd pulses
    always @(posedge clk) if (upd) upd_cnt <= upd_cnt + 1;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Press buttons for 'hold' cycles, release, then let everything settle
    task automatic press(input logic up, input logic dn, input int unsigned hold);
        btn_up   = up;
        btn_down = dn;
        tick(hold);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(30);
    endtask

    initial begin
        rst_n = 1'b0; frec_en = 1'b0; cor_en = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        tick(3);
        chk("rst_frec", frec_val, 0);
        chk("rst_cor",  cor_val,  0);
        chk("rst_upd",  upd,      0);
        rst_n = 1'b1;
        base = upd_cnt;
        tick(10);
        chk("idle_frec", frec_val, 0);
        chk("idle_cor",  cor_val,  0);
        chk("idle_upd",  upd_cnt - base, 0);

        // Clean press: value changes exactly 7 cycles after the rise, upd one cycle later
        frec_en = 1'b1; cor_en = 1'b0;
        base = upd_cnt;
        btn_up = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk("lat_frec_pre", frec_val, 0);
            chk("lat_upd_pre",  upd,      0);
        end
        tick(1);
        chk("lat_frec_7", frec_val, 1);
        chk("lat_upd_7",  upd,      0);
        tick(1);
        chk("lat_upd_8",  upd,      1);
        tick(1);
        chk("lat_upd_9",  upd,      0);
        btn_up = 1'b0;
        tick(30);
        chk("lat_frec_rel", frec_val, 1);
        chk("lat_cor",      cor_val,  0);
        chk("lat_upd_cnt",  upd_cnt - base, 1);

        // Bounce shorter than the debounce window
        base = upd_cnt;
        for (int i = 0; i < 10; i++) begin
            btn_up = ~btn_up;
            tick(2);
        end
        btn_up = 1'b0;
        tick(30);
        chk("bounce_frec", frec_val, 1);
        chk("bounce_upd",  upd_cnt - base, 0);

        // Current set-point up to the limit, then hold at the limit
        frec_en = 1'b0; cor_en = 1'b1;
        base = upd_cnt;
        press(1'b1, 1'b0, 150);
        chk("cor_to_max", cor_val, 9);
        chk("cor_to_max_upd", upd_cnt - base, 9);
        chk("cor_frec_kept", frec_val, 1);
        base = upd_cnt;
        press(1'b1, 1'b0, 100);
        chk("cor_sat_hi", cor_val, 9);
        chk("cor_sat_hi_upd", upd_cnt - base, 0);

        // Down with auto-repeat every 16 cycles
        btn_down = 1'b1;
        tick(6);
        chk("dn_pre", cor_val, 9);
        tick(1);
        chk("dn_first", cor_val, 8);
        tick(15);
        chk("dn_rpt_pre", cor_val, 8);
        tick(1);
        chk("dn_rpt1", cor_val, 7);
        tick(16);
        chk("dn_rpt2", cor_val, 6);
        tick(1);
        btn_down = 1'b0;
        tick(30);
        chk("dn_rel", cor_val, 6);

        // Frequency to 5, then simultaneous up/down and both-enabled presses
        frec_en = 1'b1; cor_en = 1'b0;
        press(1'b1, 1'b0, 60);
        chk("frec_to5", frec_val, 5);
        base = upd_cnt;
        press(1'b1, 1'b1, 10);
        chk("both_btn_frec", frec_val, 5);
        chk("both_btn_upd",  upd_cnt - base, 0);
        frec_en = 1'b1; cor_en = 1'b1;
        base = upd_cnt;
        press(1'b1, 1'b0, 10);
        chk("both_en_frec", frec_val, 5);
        chk("both_en_cor",  cor_val,  6);
        chk("both_en_upd",  upd_cnt - base, 0);

        // Selector flips during a hold: later repeats go to the current set-point
        frec_en = 1'b1; cor_en = 1'b0;
        btn_up = 1'b1;
        tick(8);
        chk("redir_first", frec_val, 6);
        tick(2);
        frec_en = 1'b0; cor_en = 1'b1;
        tick(14);
        chk("redir_rpt1_cor",  cor_val,  7);
        chk("redir_rpt1_frec", frec_val, 6);
        tick(16);
        chk("redir_rpt2_cor",  cor_val,  8);
        btn_up = 1'b0;
        tick(30);
        chk("redir_end_frec", frec_val, 6);
        chk("redir_end_cor",  cor_val,  8);

        // Reset in the middle of a debounce; a held button is a fresh press afterwards
        frec_en = 1'b1; cor_en = 1'b0;
        btn_up = 1'b1;
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_frec", frec_val, 0);
        chk("mid_rst_cor",  cor_val,  0);
        chk("mid_rst_upd",  upd,      0);
        tick(1);
        rst_n = 1'b1;
        tick(6);
        chk("fresh_pre", frec_val, 0);
        tick(1);
        chk("fresh_step", frec_val, 1);
        btn_up = 1'b0;
        tick(30);

        // Idle after reset, then a down step at zero holds
        #2 rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        base = upd_cnt;
        tick(20);
        chk("post_rst_frec", frec_val, 0);
        chk("post_rst_cor",  cor_val,  0);
        press(1'b0, 1'b1, 10);
        chk("sat_lo_frec", frec_val, 0);
        chk("sat_lo_upd",  upd_cnt - base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
